// File: rtl/neosd_cmd_phy.sv
`default_nettype none
// ============================================================================
// Module   : neosd_cmd_phy
// Purpose  : SD card CMD-line PHY: serialises 48-bit commands with CRC7 and
//            captures/validates the 48-bit response, paced by a tick-based
//            SD clock.
// Revision : 1.0 - initial release
// ============================================================================
module neosd_cmd_phy (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  clkgen_i,
    input  logic [2:0]  clk_sel_i,
    input  logic        clk_idle_en_i,
    input  logic        start_i,
    input  logic [5:0]  cmd_idx_i,
    input  logic [31:0] cmd_arg_i,
    input  logic        rsp_en_i,
    input  logic        crc_chk_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [5:0]  rsp_idx_o,
    output logic [31:0] rsp_arg_o,
    output logic [2:0]  err_o,
    output logic        sd_clk_o,
    output logic        sd_cmd_o,
    input  logic        sd_cmd_i,
    output logic        sd_cmd_oe
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_WAIT = 3'd2,
        S_RX   = 3'd3,
        S_NCC  = 3'd4
    } state_t;

    localparam logic [6:0] C_TX_CRC   = 7'd40;
    localparam logic [6:0] C_TX_STOP  = 7'd47;
    localparam logic [6:0] C_TX_END   = 7'd48;
    localparam logic [6:0] C_WAIT_MAX = 7'd63;
    localparam logic [6:0] C_RX_CRC   = 7'd39;
    localparam logic [6:0] C_RX_LAST  = 7'd46;
    localparam logic [6:0] C_NCC_LAST = 7'd7;
    localparam logic [6:0] C_CRC_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? C_CRC_POLY : 7'h00);
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sd_clk;
    logic        r_cmd_o;
    logic        r_cmd_oe;
    logic        r_done;
    logic        r_rsp_en;
    logic        r_crc_chk;
    logic [6:0]  r_cnt;
    logic [6:0]  r_crc;
    logic [39:0] r_shift;
    logic [44:0] r_rx;
    logic [5:0]  r_rsp_idx;
    logic [31:0] r_rsp_arg;
    logic [2:0]  r_err;

    logic        w_tick;
    logic        w_fall;
    logic        w_rise;
    logic        w_start;
    logic        w_tx_bit;
    logic        w_done_set;
    logic        w_cnt_inc;
    logic [45:0] w_rx_next;

    assign w_tick    = clkgen_i[clk_sel_i];
    assign w_fall    = w_tick & r_sd_clk;
    assign w_rise    = w_tick & ~r_sd_clk;
    // A start coinciding with the completion pulse is dropped on purpose.
    assign w_start   = (r_state == S_IDLE) & start_i & ~r_done;
    assign w_rx_next = {r_rx, sd_cmd_i};

    always_comb begin
        w_tx_bit = 1'b1;
        if (r_cnt < C_TX_CRC) begin
            w_tx_bit = r_shift[39];
        end else if (r_cnt < C_TX_STOP) begin
            w_tx_bit = r_crc[6];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_TX;
            end
            S_TX: begin
                if (w_fall) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == C_TX_END) w_state_nxt = r_rsp_en ? S_WAIT : S_NCC;
                end
            end
            S_WAIT: begin
                if (w_rise) begin
                    w_cnt_inc = 1'b1;
                    if (!sd_cmd_i) begin
                        w_state_nxt = S_RX;
                    end else if (r_cnt == C_WAIT_MAX) begin
                        w_state_nxt = S_NCC;
                    end
                end
            end
            S_RX: begin
                if (w_rise) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == C_RX_LAST) w_state_nxt = S_NCC;
                end
            end
            S_NCC: begin
                if (w_fall) begin
                    w_cnt_inc = 1'b1;
                    if (r_cnt == C_NCC_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_set  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sd_clk  <= 1'b0;
            r_cmd_o   <= 1'b1;
            r_cmd_oe  <= 1'b0;
            r_done    <= 1'b0;
            r_rsp_en  <= 1'b0;
            r_crc_chk <= 1'b0;
            r_cnt     <= 7'd0;
            r_crc     <= 7'd0;
            r_shift   <= 40'd0;
            r_rx      <= 45'd0;
            r_rsp_idx <= 6'd0;
            r_rsp_arg <= 32'd0;
            r_err     <= 3'd0;
        end else begin
            r_done <= w_done_set;

            if (w_tick) begin
                r_sd_clk <= ((r_state != S_IDLE) || clk_idle_en_i) ? ~r_sd_clk : 1'b0;
            end

            // Counter restarts on every state change so each phase counts from zero.
            if (w_state_nxt != r_state) begin
                r_cnt <= 7'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 7'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_shift   <= {2'b01, cmd_idx_i, cmd_arg_i};
                        r_rsp_en  <= rsp_en_i;
                        r_crc_chk <= crc_chk_i;
                        r_crc     <= 7'd0;
                        r_err     <= 3'd0;
                    end
                end
                S_TX: begin
                    if (w_fall) begin
                        if (r_cnt < C_TX_END) begin
                            r_cmd_o  <= w_tx_bit;
                            r_cmd_oe <= 1'b1;
                            if (r_cnt < C_TX_CRC) begin
                                r_shift <= {r_shift[38:0], 1'b0};
                                r_crc   <= crc7_step(r_crc, r_shift[39]);
                            end else if (r_cnt < C_TX_STOP) begin
                                r_crc <= {r_crc[5:0], 1'b0};
                            end
                        end else begin
                            r_cmd_o  <= 1'b1;
                            r_cmd_oe <= 1'b0;
                            r_crc    <= 7'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_rise) begin
                        if (!sd_cmd_i) begin
                            r_crc <= 7'd0;
                        end else if (r_cnt == C_WAIT_MAX) begin
                            r_err[0] <= 1'b1;
                        end
                    end
                end
                S_RX: begin
                    if (w_rise) begin
                        r_rx <= w_rx_next[44:0];
                        // CRC covers the received bits 46..8; the start bit adds nothing.
                        if (r_cnt < C_RX_CRC) r_crc <= crc7_step(r_crc, sd_cmd_i);
                        if (r_cnt == C_RX_LAST) begin
                            r_rsp_idx <= w_rx_next[45:40];
                            r_rsp_arg <= w_rx_next[39:8];
                            if (r_crc_chk && (w_rx_next[7:1] != r_crc)) r_err[1] <= 1'b1;
                            if (!w_rx_next[0]) r_err[2] <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign rsp_idx_o = r_rsp_idx;
    assign rsp_arg_o = r_rsp_arg;
    assign err_o     = r_err;
    assign sd_clk_o  = r_sd_clk;
    assign sd_cmd_o  = r_cmd_o;
    assign sd_cmd_oe = r_cmd_oe;

endmodule
`default_nettype wire

// File: tb/tb_neosd_cmd_phy.sv
`default_nettype none
// ============================================================================
// Module   : tb_neosd_cmd_phy
// Purpose  : Self-checking bench for neosd_cmd_phy with an SD card model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neosd_cmd_phy;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic [7:0]  clkgen_i;
    logic [2:0]  clk_sel_i;
    logic        clk_idle_en_i;
    logic        start_i;
    logic [5:0]  cmd_idx_i;
    logic [31:0] cmd_arg_i;
    logic        rsp_en_i;
    logic        crc_chk_i;
    logic        busy_o;
    logic        done_o;
    logic [5:0]  rsp_idx_o;
    logic [31:0] rsp_arg_o;
    logic [2:0]  err_o;
    logic        sd_clk_o;
    logic        sd_cmd_o;
    logic        sd_cmd_i;
    logic        sd_cmd_oe;

    logic [11:0] div_cnt = 12'd0;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] got_frame;
    int          got_bits;
    int          got_falls;
    logic        got_done;
    logic        aborted;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;

    neosd_cmd_phy dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .clkgen_i      (clkgen_i),
        .clk_sel_i     (clk_sel_i),
        .clk_idle_en_i (clk_idle_en_i),
        .start_i       (start_i),
        .cmd_idx_i     (cmd_idx_i),
        .cmd_arg_i     (cmd_arg_i),
        .rsp_en_i      (rsp_en_i),
        .crc_chk_i     (crc_chk_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .rsp_idx_o     (rsp_idx_o),
        .rsp_arg_o     (rsp_arg_o),
        .err_o         (err_o),
        .sd_clk_o      (sd_clk_o),
        .sd_cmd_o      (sd_cmd_o),
        .sd_cmd_i      (sd_cmd_i),
        .sd_cmd_oe     (sd_cmd_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) div_cnt <= div_cnt + 12'd1;

    assign clkgen_i = {&div_cnt[11:0], &div_cnt[10:0], &div_cnt[9:0], &div_cnt[6:0],
                       &div_cnt[5:0], &div_cnt[2:0], &div_cnt[1:0], div_cnt[0]};

    // Remainder of message * x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_model(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame_of(input logic [39:0] head);
        return {head, crc7_model(head), 1'b1};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                           input logic cchk, input logic silent, input logic [47:0] rsp,
                           input int dly, input int abort_at, input int sw_at);
        logic prev;
        logic ended;
        int   card_n;
        @(negedge clk);
        cmd_idx_i = idx; cmd_arg_i = arg; rsp_en_i = ren; crc_chk_i = cchk;
        sd_cmd_i = 1'b1; start_i = 1'b1;
        got_frame = '0; got_bits = 0; got_falls = 0; got_done = 1'b0; aborted = 1'b0;
        ended = 1'b0; card_n = 0;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        prev = sd_clk_o;
        for (int cyc = 0; cyc < 20000 && !got_done && !aborted; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (prev && !sd_clk_o) begin
                if (sd_cmd_oe && !ended) begin
                    got_frame = {got_frame[46:0], sd_cmd_o};
                    got_bits++;
                    if (got_bits == 5) begin
                        start_i = 1'b1; cmd_idx_i = ~idx; cmd_arg_i = ~arg;
                    end
                    if (got_bits == sw_at) clk_sel_i = 3'($urandom_range(0, 2));
                    if (got_bits == abort_at) begin
                        #1 rstn_i = 1'b0;
                        aborted = 1'b1;
                    end
                end else if (!ended && got_bits > 0) begin
                    ended = 1'b1;
                end else if (ended) begin
                    got_falls++;
                end
                if (ended && ren && !silent) begin
                    if (got_falls >= dly && card_n < 48) begin
                        sd_cmd_i = rsp[47 - card_n];
                        card_n++;
                    end else begin
                        sd_cmd_i = 1'b1;
                    end
                end
            end
            if (done_o) got_done = 1'b1;
            prev = sd_clk_o;
        end
        sd_cmd_i = 1'b1;
        if (!aborted) begin
            check("done_seen", got_done, 1);
            if (got_done) begin
                check("busy_at_done", busy_o, 0);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                check("done_one_cycle", done_o, 0);
                repeat (3) @(negedge clk);
                check("start_on_done_ignored", busy_o, 0);
            end
        end
    endtask

    task automatic check_result(input logic [47:0] exp_frame, input logic [2:0] exp_err,
                                input int exp_falls);
        check("tx_frame", got_frame, exp_frame);
        check("tx_bits", got_bits, 48);
        check("err", err_o, exp_err);
        check("falls_to_done", got_falls, exp_falls);
        check("rsp_idx", rsp_idx_o, exp_idx);
        check("rsp_arg", rsp_arg_o, exp_arg);
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rsp_idx", rsp_idx_o, 0);
        check("rst_rsp_arg", rsp_arg_o, 0);
        check("rst_sd_clk", sd_clk_o, 0);
        check("rst_sd_cmd", sd_cmd_o, 1);
        check("rst_sd_cmd_oe", sd_cmd_oe, 0);
    endtask

    task automatic measure_period(output int n);
        logic p;
        int   first;
        first = -1;
        n = -1;
        for (int c = 0; c < 400 && n < 0; c++) begin
            p = sd_clk_o;
            @(negedge clk);
            if (!p && sd_clk_o) begin
                if (first < 0) first = c;
                else n = c - first;
            end
        end
    endtask

    initial begin : stim
        logic [47:0] rsp;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        ren;
        logic        cchk;
        int          kind;
        int          dly;
        int          per;
        logic [2:0]  e;

        rstn_i = 1'b0; clk_sel_i = 3'd0; clk_idle_en_i = 1'b0; start_i = 1'b0;
        cmd_idx_i = '0; cmd_arg_i = '0; rsp_en_i = 1'b0; crc_chk_i = 1'b0; sd_cmd_i = 1'b1;
        exp_idx = '0; exp_arg = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rstn_i = 1'b1;
        repeat (2) @(negedge clk);

        // CMD0, no response
        run_cmd(6'd0, 32'd0, 1'b0, 1'b0, 1'b1, 48'd0, 0, 0, 0);
        check("cmd0_literal", got_frame, 48'h400000000095);
        check_result(frame_of({2'b01, 6'd0, 32'd0}), 3'b000, 8);

        // CMD8 with the card reply after 2 clocks
        exp_idx = 6'h08; exp_arg = 32'h000001AA;
        run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA87, 2, 0, 0);
        check("cmd8_literal", got_frame, 48'h48000001AA87);
        check_result(frame_of({2'b01, 6'd8, 32'h1AA}), 3'b000, 2 + 55);

        // silent card -> timeout, response registers hold
        run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b1, 48'd0, 0, 0, 0);
        check_result(frame_of({2'b01, 6'd8, 32'h1AA}), 3'b001, 71);

        // CRC corruption with and without checking, then a bad end bit
        run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA87 ^ 48'h2, 3, 0, 0);
        check_result(frame_of({2'b01, 6'd8, 32'h1AA}), 3'b010, 3 + 55);
        run_cmd(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b0, 48'h48000001AA87 ^ 48'h2, 3, 0, 0);
        check_result(frame_of({2'b01, 6'd8, 32'h1AA}), 3'b000, 3 + 55);
        run_cmd(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA86, 1, 0, 0);
        check_result(frame_of({2'b01, 6'd8, 32'h1AA}), 3'b100, 1 + 55);

        // idle clocking
        clk_idle_en_i = 1'b1;
        clk_sel_i = 3'd0;
        measure_period(per);
        check("idle_period_sel0", per, 4);
        check("idle_oe", sd_cmd_oe, 0);
        clk_sel_i = 3'd1;
        measure_period(per);
        check("idle_period_sel1", per, 8);
        clk_idle_en_i = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_clk_parked", sd_clk_o, 0);

        // reset in the middle of a frame
        clk_sel_i = 3'd0;
        run_cmd(6'd17, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 48'd0, 0, 20, 0);
        #1;
        exp_idx = '0; exp_arg = '0;
        check_reset_vals();
        repeat (3) @(negedge clk);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk);
        run_cmd(6'd17, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 48'd0, 0, 0, 0);
        check_result(frame_of({2'b01, 6'd17, 32'hDEADBEEF}), 3'b000, 8);

        // randomized commands, card replies and clock-select changes
        for (int it = 0; it < 8; it++) begin
            idx  = 6'($urandom);
            arg  = $urandom;
            ren  = 1'($urandom);
            cchk = 1'($urandom);
            kind = int'($urandom_range(0, 3));
            dly  = int'($urandom_range(1, 40));
            ridx = 6'($urandom);
            rarg = $urandom;
            clk_sel_i     = 3'($urandom_range(0, 2));
            clk_idle_en_i = 1'($urandom);
            rsp = frame_of({1'b0, 1'($urandom), ridx, rarg});
            if (kind == 1) rsp = rsp ^ (48'h2 << $urandom_range(0, 6));
            if (kind == 2) rsp[0] = 1'b0;
            e = 3'b000;
            if (ren && kind == 3) begin
                e = 3'b001;
            end else if (ren) begin
                e = {kind == 2, (kind == 1) && cchk, 1'b0};
                exp_idx = ridx;
                exp_arg = rarg;
            end
            run_cmd(idx, arg, ren, cchk, kind == 3, rsp, dly, 0,
                    int'($urandom_range(1, 47)));
            check_result(frame_of({2'b01, idx, arg}), e,
                         !ren ? 8 : (kind == 3 ? 71 : dly + 55));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
